rename_reg_file: RTL and testbench

- Architectural register file with rename tags, 32 x 32-bit registers.
- Sits between the decoder and the reorder buffer (ROB), on the commit-consumer side of the ROB interface.
- Accepts ROB commits and new rd→ROB-id allocations.
- Resolves decoder source-operand lookups, querying the ROB for in-flight producers.
- Clears all rename state on a misprediction flush.

---
 rtl/rename_reg_file.sv | 121 ++++++++++++
 tb/tb_rename_reg_file.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/rename_reg_file.sv
// rtl/rename_reg_file.sv - 32x32 architectural register file with ROB rename tags
// Optional commit-to-lookup bypass is enabled by defining REGFILE_COMMIT_BYPASS_EN.
module rename_reg_file #(
    parameter int ROB_WIDTH_BIT = 5
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear_flag,
    input  logic [4:0]               write_reg_id,
    input  logic [31:0]              write_val,
    input  logic [ROB_WIDTH_BIT-1:0] write_ROB_id,
    input  logic [4:0]               new_reg_id,
    input  logic [ROB_WIDTH_BIT-1:0] new_ROB_id,
    input  logic [4:0]               dec_rs1,
    input  logic [4:0]               dec_rs2,
    output logic                     rs1_ready,
    output logic [31:0]              rs1_val,
    output logic [ROB_WIDTH_BIT-1:0] rs1_dep,
    output logic                     rs2_ready,
    output logic [31:0]              rs2_val,
    output logic [ROB_WIDTH_BIT-1:0] rs2_dep,
    output logic [ROB_WIDTH_BIT-1:0] rob_rs1_id,
    input  logic                     rob_rs1_ready,
    input  logic [31:0]              rob_rs1_val,
    output logic [ROB_WIDTH_BIT-1:0] rob_rs2_id,
    input  logic                     rob_rs2_ready,
    input  logic [31:0]              rob_rs2_val
);

    typedef struct packed {
        logic                     ready;
        logic [31:0]              val;
        logic [ROB_WIDTH_BIT-1:0] dep;
        logic [ROB_WIDTH_BIT-1:0] rob_id;
    } lookup_t;

    logic [31:0]              val_q  [32];
    logic                     busy_q [32];
    logic [ROB_WIDTH_BIT-1:0] tag_q  [32];

    // Entry 0 is never written after reset, so x0 stays zero and idle.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < 32; i++) begin
                val_q[i]  <= '0;
                busy_q[i] <= 1'b0;
                tag_q[i]  <= '0;
            end
        end else if (rdy_in) begin
            if (write_reg_id != 5'd0) begin
                val_q[write_reg_id] <= write_val;
                if (tag_q[write_reg_id] == write_ROB_id)
                    busy_q[write_reg_id] <= 1'b0;
            end
            if (clear_flag) begin
                for (int i = 0; i < 32; i++) begin
                    busy_q[i] <= 1'b0;
                    tag_q[i]  <= '0;
                end
            end else if (new_reg_id != 5'd0) begin
                // Issued after the commit update so a same-register allocation wins.
                busy_q[new_reg_id] <= 1'b1;
                tag_q[new_reg_id]  <= new_ROB_id;
            end
        end
    end

    function automatic lookup_t lookup(
        input logic [4:0]               rs,
        input logic                     busy,
        input logic [31:0]              v,
        input logic [ROB_WIDTH_BIT-1:0] t,
        input logic                     rob_ready,
        input logic [31:0]              rob_val
    );
        lookup_t l;
        logic    bypass_hit;
        l          = '0;
        l.ready    = 1'b1;
        bypass_hit = 1'b0;
`ifdef REGFILE_COMMIT_BYPASS_EN
        bypass_hit = (write_reg_id == rs) && (t == write_ROB_id);
`endif
        if (rs == 5'd0) begin
            l.val = '0;
        end else if (!busy) begin
            l.val = v;
        end else if (bypass_hit) begin
            l.val = write_val;
        end else begin
            l.rob_id = t;
            if (rob_ready) begin
                l.val = rob_val;
            end else begin
                l.ready = 1'b0;
                l.dep   = t;
            end
        end
        return l;
    endfunction

    lookup_t lk1, lk2;

    always_comb begin
        lk1 = lookup(dec_rs1, busy_q[dec_rs1], val_q[dec_rs1], tag_q[dec_rs1],
                     rob_rs1_ready, rob_rs1_val);
        lk2 = lookup(dec_rs2, busy_q[dec_rs2], val_q[dec_rs2], tag_q[dec_rs2],
                     rob_rs2_ready, rob_rs2_val);
    end

    assign rs1_ready  = lk1.ready;
    assign rs1_val    = lk1.val;
    assign rs1_dep    = lk1.dep;
    assign rob_rs1_id = lk1.rob_id;
    assign rs2_ready  = lk2.ready;
    assign rs2_val    = lk2.val;
    assign rs2_dep    = lk2.dep;
    assign rob_rs2_id = lk2.rob_id;

endmodule

// File: tb/tb_rename_reg_file.sv
// tb/tb_rename_reg_file.sv - directed self-checking bench for rename_reg_file
module tb_rename_reg_file;

    localparam int W = 5;

    logic          clk_in = 1'b0;
    logic          rst_in, rdy_in, clear_flag;
    logic [4:0]    write_reg_id, new_reg_id, dec_rs1, dec_rs2;
    logic [31:0]   write_val, rob_rs1_val, rob_rs2_val;
    logic [W-1:0]  write_ROB_id, new_ROB_id;
    logic          rob_rs1_ready, rob_rs2_ready;
    logic          rs1_ready, rs2_ready;
    logic [31:0]   rs1_val, rs2_val;
    logic [W-1:0]  rs1_dep, rs2_dep, rob_rs1_id, rob_rs2_id;

    int checks = 0;
    int failures = 0;

    rename_reg_file #(.ROB_WIDTH_BIT(W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_flag(clear_flag),
        .write_reg_id(write_reg_id), .write_val(write_val), .write_ROB_id(write_ROB_id),
        .new_reg_id(new_reg_id), .new_ROB_id(new_ROB_id),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .rs1_ready(rs1_ready), .rs1_val(rs1_val), .rs1_dep(rs1_dep),
        .rs2_ready(rs2_ready), .rs2_val(rs2_val), .rs2_dep(rs2_dep),
        .rob_rs1_id(rob_rs1_id), .rob_rs1_ready(rob_rs1_ready), .rob_rs1_val(rob_rs1_val),
        .rob_rs2_id(rob_rs2_id), .rob_rs2_ready(rob_rs2_ready), .rob_rs2_val(rob_rs2_val)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        write_reg_id = 0; write_val = 0; write_ROB_id = 0;
        new_reg_id = 0; new_ROB_id = 0; clear_flag = 0;
    endtask

    task automatic alloc(input logic [4:0] rd, input logic [W-1:0] id);
        new_reg_id = rd; new_ROB_id = id;
        tick();
    endtask

    initial begin
        rst_in = 1; rdy_in = 1; clear_flag = 0;
        write_reg_id = 0; write_val = 0; write_ROB_id = 0;
        new_reg_id = 0; new_ROB_id = 0; dec_rs1 = 5; dec_rs2 = 0;
        rob_rs1_ready = 0; rob_rs1_val = 0; rob_rs2_ready = 0; rob_rs2_val = 0;
        #3;
        check("reset_rs1_ready", rs1_ready, 1);
        check("reset_rs1_val", rs1_val, 0);
        check("reset_rs1_dep", rs1_dep, 0);
        check("reset_rob_rs1_id", rob_rs1_id, 0);
        @(posedge clk_in); #1; rst_in = 0;

        // Allocate x5 -> ROB 7, then query through the ROB.
        alloc(5, 7);
        dec_rs1 = 5; rob_rs1_ready = 0; #1;
        check("alloc_rob_id", rob_rs1_id, 7);
        check("alloc_ready", rs1_ready, 0);
        check("alloc_dep", rs1_dep, 7);
        check("alloc_val", rs1_val, 0);
        rob_rs1_ready = 1; rob_rs1_val = 32'h1234; #1;
        check("fwd_ready", rs1_ready, 1);
        check("fwd_val", rs1_val, 32'h1234);
        check("fwd_dep", rs1_dep, 0);
        rob_rs1_ready = 0; rob_rs1_val = 0;

        // Younger producer survives an older commit.
        alloc(5, 9);
        write_reg_id = 5; write_ROB_id = 7; write_val = 32'hAA;
        tick();
        check("stale_commit_ready", rs1_ready, 0);
        check("stale_commit_dep", rs1_dep, 9);
        clear_flag = 1;
        tick();
        check("stale_commit_val", rs1_val, 32'hAA);
        check("stale_commit_idle", rs1_ready, 1);

        // rdy_in low freezes state.
        rdy_in = 0; new_reg_id = 5; new_ROB_id = 3; write_reg_id = 5; write_val = 32'hBAD;
        tick();
        rdy_in = 1;
        check("paused_ready", rs1_ready, 1);
        check("paused_val", rs1_val, 32'hAA);

        // Same-cycle commit and allocate to x6.
        write_reg_id = 6; write_ROB_id = 2; write_val = 32'h55;
        new_reg_id = 6; new_ROB_id = 4;
        tick();
        dec_rs2 = 6; #1;
        check("same_cyc_ready", rs2_ready, 0);
        check("same_cyc_dep", rs2_dep, 4);
        check("same_cyc_rob_id", rob_rs2_id, 4);

        // Flush with x1..x3 busy, commit to x1 and a dropped allocation of x2.
        alloc(1, 1); alloc(2, 2); alloc(3, 3);
        dec_rs1 = 2; #1;
        check("pre_flush_dep", rs1_dep, 2);
        clear_flag = 1; write_reg_id = 1; write_ROB_id = 9; write_val = 32'h10;
        new_reg_id = 2; new_ROB_id = 5;
        tick();
        dec_rs1 = 1; #1;
        check("flush_x1_ready", rs1_ready, 1);
        check("flush_x1_val", rs1_val, 32'h10);
        dec_rs1 = 2; #1;
        check("flush_x2_ready", rs1_ready, 1);
        check("flush_x2_rob_id", rob_rs1_id, 0);
        dec_rs1 = 3; #1;
        check("flush_x3_ready", rs1_ready, 1);
        check("flush_x6_ready", rs2_ready, 1);
        check("flush_x6_val", rs2_val, 32'h55);

        // x0 ignores writes and allocations.
        write_reg_id = 0; write_val = 32'hFF; new_reg_id = 0; new_ROB_id = 6;
        tick();
        dec_rs2 = 0; rob_rs2_ready = 1; rob_rs2_val = 32'hDEAD; #1;
        check("x0_ready", rs2_ready, 1);
        check("x0_val", rs2_val, 0);
        check("x0_dep", rs2_dep, 0);
        check("x0_rob_id", rob_rs2_id, 0);
        rob_rs2_ready = 0; rob_rs2_val = 0;

        // Commit of x8 while it is being looked up.
        alloc(8, 1);
        write_reg_id = 8; write_ROB_id = 1; write_val = 32'h77;
        dec_rs1 = 8; rob_rs1_ready = 0; #1;
`ifdef REGFILE_COMMIT_BYPASS_EN
        check("bypass_ready", rs1_ready, 1);
        check("bypass_val", rs1_val, 32'h77);
        check("bypass_rob_id", rob_rs1_id, 0);
`else
        check("nobypass_ready", rs1_ready, 0);
        check("nobypass_dep", rs1_dep, 1);
        check("nobypass_rob_id", rob_rs1_id, 1);
`endif
        tick();
        check("commit_x8_ready", rs1_ready, 1);
        check("commit_x8_val", rs1_val, 32'h77);

        // Asynchronous reset mid-cycle with x5 busy on tag 3.
        alloc(5, 3);
        dec_rs1 = 5; #1;
        check("pre_rst_dep", rs1_dep, 3);
        #1; rst_in = 1; #1;
        check("async_rst_ready", rs1_ready, 1);
        check("async_rst_val", rs1_val, 0);
        check("async_rst_dep", rs1_dep, 0);
        check("async_rst_rob_id", rob_rs1_id, 0);
        dec_rs1 = 8; #1;
        check("async_rst_x8_val", rs1_val, 0);
        rst_in = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
